// File: rtl/kernel_stall_detector.sv
// Kernel stall detector: flags deadlock when a non-idle kernel shows the same nonzero block pattern for STALL_THRESH consecutive edges.
// Optional macro KERNEL_STALL_DETECTOR_TIMESTAMP_EN adds a free-running cycle counter that stamps block_time.
module kernel_stall_detector #(
  parameter int N_AXIS       = 2,
  parameter int N_INST       = 2,
  parameter int STALL_THRESH = 16,
  localparam int CW          = $clog2(STALL_THRESH + 1),
  localparam int SW          = N_AXIS + N_INST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic [N_AXIS-1:0] block_axis_mask,
  output logic [N_INST-1:0] block_inst_mask,
  output logic [CW-1:0]     stall_cnt,
  output logic [31:0]       block_time
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STALL_THRESH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STALL_THRESH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t        state_reg;
  logic [SW-1:0] sig;
  logic [SW-1:0] sig_q;
  logic [SW-1:0] sig_diff;
  logic          active;
  logic          stall_cond;
  logic          sig_same;

  assign sig        = {axis_block_sigs, inst_block_sigs};
  assign active     = ~(&inst_idle_sigs);
  assign stall_cond = active & (|sig);

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_diff
      assign sig_diff[gi] = sig[gi] ^ sig_q[gi];
    end
  endgenerate

  // A run only counts while the exact same set of blockers persists.
  assign sig_same = ~(|sig_diff);

`ifdef KERNEL_STALL_DETECTOR_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_next;

  // cycle_next is the number of edges since reset, including the current one.
  assign cycle_next = cycle_cnt + 32'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_next;
    end
  end
`else
  assign block_time = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      block           <= 1'b0;
      block_axis_mask <= '0;
      block_inst_mask <= '0;
      stall_cnt       <= '0;
      sig_q           <= '0;
`ifdef KERNEL_STALL_DETECTOR_TIMESTAMP_EN
      block_time      <= '0;
`endif
    end else if (clear) begin
      state_reg       <= IDLE;
      block           <= 1'b0;
      block_axis_mask <= '0;
      block_inst_mask <= '0;
      stall_cnt       <= '0;
      sig_q           <= '0;
`ifdef KERNEL_STALL_DETECTOR_TIMESTAMP_EN
      block_time      <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (stall_cond) begin
            state_reg <= COUNT;
            stall_cnt <= CNT_ONE;
            sig_q     <= sig;
          end else begin
            stall_cnt <= '0;
          end
        end
        COUNT: begin
          if (!stall_cond) begin
            state_reg <= IDLE;
            stall_cnt <= '0;
          end else if (!sig_same) begin
            stall_cnt <= CNT_ONE;
            sig_q     <= sig;
          end else if (stall_cnt == CNT_LAST) begin
            state_reg       <= BLOCKED;
            block           <= 1'b1;
            stall_cnt       <= CNT_FULL;
            block_axis_mask <= axis_block_sigs;
            block_inst_mask <= inst_block_sigs;
`ifdef KERNEL_STALL_DETECTOR_TIMESTAMP_EN
            block_time      <= cycle_next;
`endif
          end else begin
            stall_cnt <= stall_cnt + CNT_ONE;
          end
        end
        BLOCKED: begin
          // Sticky: everything holds until clear or reset.
          state_reg <= BLOCKED;
        end
        default: begin
          state_reg <= IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_stall_detector.sv
// Directed table-driven bench for kernel_stall_detector (defaults N_AXIS=2, N_INST=2, STALL_THRESH=16).
// Hand-written sequences cover asynchronous reset mid-run and the block_time stamp.
module tb_kernel_stall_detector;

  logic       clock;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [1:0] inst_idle_sigs;
  logic [1:0] inst_block_sigs;
  logic       clear;
  logic       block;
  logic [1:0] block_axis_mask;
  logic [1:0] block_inst_mask;
  logic [4:0] stall_cnt;
  logic [31:0] block_time;

  int n_vec;
  int n_bad;

  kernel_stall_detector #(
    .N_AXIS(2),
    .N_INST(2),
    .STALL_THRESH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .clear(clear),
    .block(block),
    .block_axis_mask(block_axis_mask),
    .block_inst_mask(block_inst_mask),
    .stall_cnt(stall_cnt),
    .block_time(block_time)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] idle;
    logic [1:0] axis;
    logic [1:0] iblk;
    logic       clr;
    logic       exp_block;
    logic [4:0] exp_cnt;
    logic [1:0] exp_amask;
    logic [1:0] exp_imask;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] idle, input logic [1:0] axis,
                              input logic [1:0] iblk, input logic clr,
                              input logic eb, input int ec,
                              input logic [1:0] eam, input logic [1:0] eim,
                              input string name);
    vec_t v;
    v.idle = idle; v.axis = axis; v.iblk = iblk; v.clr = clr;
    v.exp_block = eb; v.exp_cnt = 5'(ec); v.exp_amask = eam; v.exp_imask = eim;
    v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic eb, input logic [4:0] ec,
                       input logic [1:0] eam, input logic [1:0] eim);
    n_vec++;
    if (block !== eb || stall_cnt !== ec || block_axis_mask !== eam || block_inst_mask !== eim) begin
      n_bad++;
      $display("FAIL %s: got block=%b cnt=%0d amask=%b imask=%b, want block=%b cnt=%0d amask=%b imask=%b",
               name, block, stall_cnt, block_axis_mask, block_inst_mask, eb, ec, eam, eim);
    end else begin
      $display("ok   %s: block=%b cnt=%0d amask=%b imask=%b", name, block, stall_cnt,
               block_axis_mask, block_inst_mask);
    end
  endtask

  task automatic check_time(input string name, input logic [31:0] exp);
    n_vec++;
    if (block_time !== exp) begin
      n_bad++;
      $display("FAIL %s: got block_time=%0d, want %0d", name, block_time, exp);
    end else begin
      $display("ok   %s: block_time=%0d", name, block_time);
    end
  endtask

  task automatic apply(input vec_t v);
    inst_idle_sigs  = v.idle;
    axis_block_sigs = v.axis;
    inst_block_sigs = v.iblk;
    clear           = v.clr;
    @(posedge clock);
    #1;
    check(v.name, v.exp_block, v.exp_cnt, v.exp_amask, v.exp_imask);
  endtask

  task automatic drive(input logic [1:0] idle, input logic [1:0] axis, input logic [1:0] iblk);
    vec_t v;
    v.idle = idle; v.axis = axis; v.iblk = iblk; v.clr = 1'b0;
    inst_idle_sigs  = v.idle;
    axis_block_sigs = v.axis;
    inst_block_sigs = v.iblk;
    clear           = v.clr;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset(input string name);
    #3;
    reset = 1'b1;
    #1;
    check(name, 1'b0, 5'd0, 2'b00, 2'b00);
    check_time({name, "_time"}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    clear = 1'b0;
    axis_block_sigs = 2'b00;
    inst_idle_sigs  = 2'b11;
    inst_block_sigs = 2'b00;

    // Basic run on axis bit 0 reaching the threshold exactly at edge 16.
    for (int k = 1; k <= 16; k++)
      add(2'b01, 2'b01, 2'b00, 1'b0, k == 16, k, (k == 16) ? 2'b01 : 2'b00, 2'b00, $sformatf("run_a%0d", k));
    // Sticky while inputs go quiet.
    for (int k = 0; k < 50; k++)
      add(2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 16, 2'b01, 2'b00, $sformatf("sticky%0d", k));
    // Clear wins over a present stall condition.
    add(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 0, 2'b00, 2'b00, "clear_blocked");
    // Pattern change at edge 10 restarts the run.
    for (int k = 1; k <= 9; k++)
      add(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, k, 2'b00, 2'b00, $sformatf("pre_chg%0d", k));
    for (int k = 1; k <= 16; k++)
      add(2'b01, 2'b10, 2'b00, 1'b0, k == 16, k, (k == 16) ? 2'b10 : 2'b00, 2'b00, $sformatf("post_chg%0d", k));
    add(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 0, 2'b00, 2'b00, "clear_quiet");
    // All instances idle: never a stall even with every block bit set.
    for (int k = 0; k < 100; k++)
      add(2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 0, 2'b00, 2'b00, $sformatf("all_idle%0d", k));
    // Active but nothing blocked.
    add(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, "active_noblock");
    // Internal instance block path.
    for (int k = 1; k <= 16; k++)
      add(2'b10, 2'b00, 2'b10, 1'b0, k == 16, k, 2'b00, (k == 16) ? 2'b10 : 2'b00, $sformatf("run_inst%0d", k));
    add(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 0, 2'b00, 2'b00, "clear_inst");
    // Stall condition dropping mid-run returns to zero.
    for (int k = 1; k <= 5; k++)
      add(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, k, 2'b00, 2'b00, $sformatf("drop_a%0d", k));
    add(2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, "drop_gone");
    for (int k = 1; k <= 3; k++)
      add(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, k, 2'b00, 2'b00, $sformatf("drop_b%0d", k));
    add(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, "drop_quiet");
    // Clear mid-count ignores the stall in its own cycle.
    for (int k = 1; k <= 4; k++)
      add(2'b01, 2'b11, 2'b01, 1'b0, 1'b0, k, 2'b00, 2'b00, $sformatf("clr_mid%0d", k));
    add(2'b01, 2'b11, 2'b01, 1'b1, 1'b0, 0, 2'b00, 2'b00, "clr_mid_clear");
    add(2'b01, 2'b11, 2'b01, 1'b0, 1'b0, 1, 2'b00, 2'b00, "clr_mid_restart1");
    add(2'b01, 2'b11, 2'b01, 1'b0, 1'b0, 2, 2'b00, 2'b00, "clr_mid_restart2");
    add(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, "clr_mid_quiet");
    // Inst-bit change mid-run restarts the count.
    for (int k = 1; k <= 7; k++)
      add(2'b00, 2'b00, 2'b01, 1'b0, 1'b0, k, 2'b00, 2'b00, $sformatf("ichg_a%0d", k));
    add(2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1, 2'b00, 2'b00, "ichg_b1");
    add(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 0, 2'b00, 2'b00, "ichg_quiet");

    @(posedge clock);
    #1;
    check("reset_state", 1'b0, 5'd0, 2'b00, 2'b00);
    check_time("reset_time", 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset at stall_cnt=12 discards the run.
    for (int k = 1; k <= 12; k++) begin
      drive(2'b01, 2'b01, 2'b00);
    end
    check("rst_pre12", 1'b0, 5'd12, 2'b00, 2'b00);
    pulse_reset("rst_async");
    for (int k = 1; k <= 15; k++) begin
      drive(2'b01, 2'b01, 2'b00);
    end
    check("rst_rerun15", 1'b0, 5'd15, 2'b00, 2'b00);
    drive(2'b01, 2'b01, 2'b00);
    check("rst_rerun16", 1'b1, 5'd16, 2'b01, 2'b00);
`ifdef KERNEL_STALL_DETECTOR_TIMESTAMP_EN
    check_time("rst_rerun_time", 32'd16);
`else
    check_time("rst_rerun_time", 32'd0);
`endif

    // Reset in BLOCKED, then a run starting at edge 5 after release.
    pulse_reset("rst_blocked");
    for (int k = 1; k <= 4; k++) begin
      drive(2'b11, 2'b00, 2'b00);
    end
    for (int k = 5; k <= 20; k++) begin
      drive(2'b01, 2'b10, 2'b00);
    end
    check("ts_block", 1'b1, 5'd16, 2'b10, 2'b00);
`ifdef KERNEL_STALL_DETECTOR_TIMESTAMP_EN
    check_time("ts_time", 32'd20);
`else
    check_time("ts_time", 32'd0);
`endif
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("ts_clear", 1'b0, 5'd0, 2'b00, 2'b00);
    check_time("ts_clear_time", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
